instruction_fetch_queue: RTL and testbench

//  Fetch stage placed upstream of the MIPS datapath. Owns the fetch PC and issues word

---
 rtl/instruction_fetch_queue_if.sv | 40 ++++
 rtl/instruction_fetch_queue.sv | 137 +++++++++++++
 tb/tb_instruction_fetch_queue.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_queue_if.sv
// Bundles the instruction-memory request channel, the redirect input and
// the decode-side instruction stream of the fetch queue into one interface.
interface instruction_fetch_queue_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          imem_req;
   logic [31:0]   imem_addr;
   logic          imem_ack;
   logic [31:0]   imem_rdata;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          ins_valid;
   logic          ins_ready;
   logic [31:0]   ins_data;
   logic [31:0]   ins_pc;
   logic [31:0]   ins_pc_plus4;
   logic [CW-1:0] count;

   // The fetch queue drives requests and the instruction stream
   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      input  redirect_valid, redirect_pc,
      output ins_valid,
      input  ins_ready,
      output ins_data, ins_pc, ins_pc_plus4, count
   );

   // Memory, redirect source and decode seen from the other side
   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      output redirect_valid, redirect_pc,
      input  ins_valid,
      output ins_ready,
      input  ins_data, ins_pc, ins_pc_plus4, count
   );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one outstanding word read at a time
// to instruction memory and buffers fetched {pc, instruction} pairs in a
// show-ahead FIFO for decode. A redirect flushes the FIFO and restarts
// fetching at the target; a request orphaned by the redirect is drained in
// DROP and its data thrown away.
module instruction_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                       clk_i,
   input logic                       rst_n_i,
   instruction_fetch_queue_if.master fetchBus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t        state_q, state_d;
   logic          imemReq_q, imemReq_d;
   logic [31:0]   imemAddr_q, imemAddr_d;
   logic [31:0]   fetchPc_q, fetchPc_d;
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   memData_q [DEPTH];
   logic [31:0]   memPc_q   [DEPTH];

   logic          ackValid;
   logic          pop;
   logic          push;
   logic [CW-1:0] countAfterPush;

   // Next-state, request and FIFO bookkeeping; redirect beats push beats pop
   always_comb begin
      state_d    = state_q;
      imemReq_d  = imemReq_q;
      imemAddr_d = imemAddr_q;
      fetchPc_d  = fetchPc_q;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      push       = 1'b0;

      ackValid       = fetchBus.imem_ack && imemReq_q;
      pop            = (count_q != '0) && fetchBus.ins_ready;
      countAfterPush = count_q + CW'(1) - CW'(pop);

      if (fetchBus.redirect_valid) begin
         fetchPc_d = fetchBus.redirect_pc & ~32'd3;
         count_d   = '0;
         wrPtr_d   = '0;
         rdPtr_d   = '0;
         if (ackValid) begin
            imemReq_d = 1'b0;
            state_d   = IDLE;
         end else if (state_q == IDLE) begin
            state_d = IDLE;
         end else begin
            state_d = DROP;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (count_q < FULL) begin
                  imemReq_d  = 1'b1;
                  imemAddr_d = fetchPc_q;
                  state_d    = WAIT;
               end
            end
            WAIT: begin
               if (ackValid) begin
                  push      = 1'b1;
                  fetchPc_d = fetchPc_q + 32'd4;
                  if (countAfterPush < FULL) begin
                     imemAddr_d = fetchPc_q + 32'd4;
                  end else begin
                     imemReq_d = 1'b0;
                     state_d   = IDLE;
                  end
               end
            end
            DROP: begin
               if (ackValid) begin
                  imemAddr_d = fetchPc_q;
                  state_d    = WAIT;
               end
            end
            default: begin
               imemReq_d = 1'b0;
               state_d   = IDLE;
            end
         endcase
         count_d = count_q + CW'(push) - CW'(pop);
         wrPtr_d = wrPtr_q + PW'(push);
         rdPtr_d = rdPtr_q + PW'(pop);
      end
   end

   // Control registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         imemReq_q  <= 1'b0;
         imemAddr_q <= RESET_PC;
         fetchPc_q  <= RESET_PC;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         imemReq_q  <= imemReq_d;
         imemAddr_q <= imemAddr_d;
         fetchPc_q  <= fetchPc_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage; contents need no reset because count gates validity
   always_ff @(posedge clk_i) begin
      if (rst_n_i && push) begin
         memData_q[wrPtr_q] <= fetchBus.imem_rdata;
         memPc_q[wrPtr_q]   <= fetchPc_q;
      end
   end

   assign fetchBus.imem_req     = imemReq_q;
   assign fetchBus.imem_addr    = imemAddr_q;
   assign fetchBus.ins_valid    = (count_q != '0);
   assign fetchBus.ins_data     = memData_q[rdPtr_q];
   assign fetchBus.ins_pc       = memPc_q[rdPtr_q];
   assign fetchBus.ins_pc_plus4 = memPc_q[rdPtr_q] + 32'd4;
   assign fetchBus.count        = count_q;
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed scenarios with
// literal expectations followed by randomized memory latency, redirects,
// decode back-pressure and resets, all checked against a queue-based model.
module tb_instruction_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   logic clk;
   logic rstN;
   int   testsRun;
   int   testsFailed;

   // Reference model: what is buffered, where fetching continues, and the
   // single outstanding request (if any) together with whether it is orphaned
   entry_t      mq[$];
   logic [31:0] mFetch;
   logic        mReq;
   logic [31:0] mAddr;
   logic        mOrphan;

   instruction_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

   instruction_fetch_queue #(
      .DEPTH   (DEPTH),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rstN),
      .fetchBus(bus.master)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model across one clock edge with the inputs the DUT saw
   task automatic modelUpdate(input logic rn, input logic ack, input logic redir,
                              input logic [31:0] rpc, input logic ready);
      logic   ackOk;
      logic   doPop;
      int     oldSize;
      entry_t e;
      if (!rn) begin
         mq.delete();
         mFetch  = RESET_PC;
         mReq    = 1'b0;
         mAddr   = RESET_PC;
         mOrphan = 1'b0;
         return;
      end
      ackOk   = ack && mReq;
      oldSize = mq.size();
      doPop   = (oldSize > 0) && ready;
      if (redir) begin
         mq.delete();
         mFetch = rpc & ~32'd3;
         if (ackOk) begin
            mReq    = 1'b0;
            mOrphan = 1'b0;
         end else if (mReq) begin
            mOrphan = 1'b1;
         end
      end else begin
         if (doPop) e = mq.pop_front();
         if (ackOk && mOrphan) begin
            mOrphan = 1'b0;
            mAddr   = mFetch;
         end else if (ackOk) begin
            e.pc   = mFetch;
            e.data = memWord(mFetch);
            mq.push_back(e);
            mFetch = mFetch + 32'd4;
            if (mq.size() < DEPTH) mAddr = mFetch;
            else                   mReq  = 1'b0;
         end else if (!mReq && oldSize < DEPTH) begin
            mReq  = 1'b1;
            mAddr = mFetch;
         end
      end
   endtask

   // Compare every visible output against the model
   task automatic checkOutput();
      checkVal("imem_req",  32'(bus.imem_req),  32'(mReq));
      checkVal("imem_addr", bus.imem_addr,      mAddr);
      checkVal("count",     32'(bus.count),     32'(mq.size()));
      checkVal("ins_valid", 32'(bus.ins_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         checkVal("ins_data",     bus.ins_data,     mq[0].data);
         checkVal("ins_pc",       bus.ins_pc,       mq[0].pc);
         checkVal("ins_pc_plus4", bus.ins_pc_plus4, mq[0].pc + 32'd4);
      end
   endtask

   // Drive one cycle of inputs (called at a falling edge), let the edge
   // happen, update the model and check at the following falling edge
   task automatic applyStimulus(input logic rn, input logic ack, input logic redir,
                                input logic [31:0] rpc, input logic ready);
      rstN               = rn;
      bus.imem_ack       = ack;
      bus.imem_rdata     = (ack && mReq) ? memWord(mAddr) : $urandom;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      bus.ins_ready      = ready;
      @(posedge clk);
      modelUpdate(rn, ack, redir, rpc, ready);
      @(negedge clk);
      checkOutput();
   endtask

   // Directed scenarios, then a long randomized run
   initial begin
      logic        rn, ack, redir, ready;
      logic [31:0] rpc;
      testsRun    = 0;
      testsFailed = 0;
      mq.delete();
      mFetch  = RESET_PC;
      mReq    = 1'b0;
      mAddr   = RESET_PC;
      mOrphan = 1'b0;
      rstN               = 1'b0;
      bus.imem_ack       = 1'b0;
      bus.imem_rdata     = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.ins_ready      = 1'b0;
      @(negedge clk);

      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkVal("lit reset req",   32'(bus.imem_req),  0);
      checkVal("lit reset addr",  bus.imem_addr,      32'h0);
      checkVal("lit reset count", 32'(bus.count),     0);
      checkVal("lit reset valid", 32'(bus.ins_valid), 0);

      applyStimulus(1, 0, 0, 0, 0);
      checkVal("lit first req",  32'(bus.imem_req), 1);
      checkVal("lit first addr", bus.imem_addr,     32'h0);

      applyStimulus(1, 1, 0, 0, 0);
      checkVal("lit push1 count", 32'(bus.count), 1);
      checkVal("lit push1 addr",  bus.imem_addr,  32'h4);
      checkVal("lit push1 pc",    bus.ins_pc,     32'h0);
      checkVal("lit push1 data",  bus.ins_data,   memWord(32'h0));

      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0);
      checkVal("lit full count", 32'(bus.count),    4);
      checkVal("lit full req",   32'(bus.imem_req), 0);
      checkVal("lit model full", 32'(mq.size()),    4);
      applyStimulus(1, 0, 0, 0, 0);
      checkVal("lit full hold req", 32'(bus.imem_req), 0);
      applyStimulus(1, 0, 0, 0, 1);
      checkVal("lit pop count", 32'(bus.count),    3);
      checkVal("lit pop req",   32'(bus.imem_req), 0);
      checkVal("lit pop pc",    bus.ins_pc,        32'h4);
      applyStimulus(1, 0, 0, 0, 0);
      checkVal("lit resume req",  32'(bus.imem_req), 1);
      checkVal("lit resume addr", bus.imem_addr,     32'h10);

      applyStimulus(1, 0, 1, 32'h102, 0);
      checkVal("lit drop count", 32'(bus.count),    0);
      checkVal("lit drop req",   32'(bus.imem_req), 1);
      checkVal("lit drop addr",  bus.imem_addr,     32'h10);
      applyStimulus(1, 1, 0, 0, 0);
      checkVal("lit drop ack addr",  bus.imem_addr,  32'h100);
      checkVal("lit drop ack count", 32'(bus.count), 0);
      applyStimulus(1, 1, 0, 0, 0);
      checkVal("lit target pc", bus.ins_pc, 32'h100);

      applyStimulus(1, 1, 0, 0, 0);
      checkVal("lit two count", 32'(bus.count), 2);
      applyStimulus(1, 1, 1, 32'h200, 0);
      checkVal("lit redir ack count", 32'(bus.count),    0);
      checkVal("lit redir ack req",   32'(bus.imem_req), 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkVal("lit redir ack addr", bus.imem_addr, 32'h200);

      applyStimulus(1, 0, 1, 32'hFFFF_FFFF, 0);
      applyStimulus(1, 1, 0, 0, 0);
      checkVal("lit top addr", bus.imem_addr, 32'hFFFF_FFFC);
      applyStimulus(1, 1, 0, 0, 0);
      checkVal("lit top pc",    bus.ins_pc,       32'hFFFF_FFFC);
      checkVal("lit top plus4", bus.ins_pc_plus4, 32'h0);
      checkVal("lit wrap addr", bus.imem_addr,    32'h0);

      applyStimulus(0, 0, 0, 0, 0);
      checkVal("lit rst wait req",   32'(bus.imem_req), 0);
      checkVal("lit rst wait count", 32'(bus.count),    0);
      applyStimulus(1, 1, 0, 0, 0);
      checkVal("lit late ack count", 32'(bus.count),    0);
      checkVal("lit late ack req",   32'(bus.imem_req), 1);
      checkVal("lit late ack addr",  bus.imem_addr,     RESET_PC);

      for (int cyc = 0; cyc < 4000; cyc++) begin
         rn    = ($urandom_range(0, 299) != 0);
         ack   = mReq ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
         redir = ($urandom_range(0, 24) == 0);
         rpc   = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                             : $urandom;
         ready = ((cyc / 64) % 3 == 1) ? ($urandom_range(0, 7) == 0)
                                       : ($urandom_range(0, 3) != 0);
         applyStimulus(rn, ack, redir, rpc, ready);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
